if_stage: RTL and testbench

- Instruction-fetch stage of the RV32I core, directly upstream of the instruction-format classifier and decode.
- Owns the PC and issues single-outstanding word fetches to instruction memory over a valid/ready request and valid response interface.
- Holds each fetched word in a one-entry IF/ID output register with a valid/ready handshake.
- Exposes instr[6:0] for the format classifier.
- Accepts PC redirects from branch/jump resolution and flushes stale fetches.

---
 rtl/if_pkg.sv | 13 +
 rtl/if_id_reg.sv | 48 ++++
 rtl/if_stage.sv | 108 ++++++++++
 tb/tb_if_stage.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package if_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;
endpackage

// File: rtl/if_id_reg.sv
// One-entry IF/ID register with load/flush/hold and delivered-instruction count.
module if_id_reg
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] din_instr,
    input  logic [XLEN-1:0] din_pc,
    input  logic            ready,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] count
);
    logic fire;

    assign fire = valid && ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            instr <= din_instr;
            pc    <= din_pc;
        end else if (fire) begin
            valid <= 1'b0;
        end
    end

    // A flushed transfer was still accepted downstream, so it counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (fire) begin
            count <= count + 32'd1;
        end
    end
endmodule

// File: rtl/if_stage.sv
// RV32I fetch stage: PC, single-outstanding imem fetch FSM, IF/ID output.
module if_stage
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  id_op,
    output logic        fetch_misaligned,
    output logic [31:0] fetch_count
);
    state_t      state;
    state_t      state_n;
    logic [31:0] pc;
    logic        started;
    logic        slot_free;
    logic        req_fire;
    logic        load;

    assign slot_free = !id_valid || id_ready;
    // No request while in reset or on the edge that releases it.
    assign imem_req_valid = started && (state == REQ) && slot_free;
    assign imem_addr = pc;
    assign req_fire = imem_req_valid && imem_req_ready;
    assign load = (state == WAIT) && imem_rsp_valid && !redirect_valid;
    assign id_op = id_instr[6:0];

    always_comb begin
        state_n = state;
        unique case (state)
            REQ: begin
                if (req_fire) begin
                    state_n = redirect_valid ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_n = REQ;
                end else if (redirect_valid) begin
                    state_n = DROP;
                end
            end
            DROP: begin
                if (imem_rsp_valid) begin
                    state_n = REQ;
                end
            end
            default: state_n = REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= REQ;
            started <= 1'b0;
        end else begin
            state   <= state_n;
            started <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[31:2], 2'b00};
        end else if (load) begin
            pc <= pc + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_misaligned <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            fetch_misaligned <= 1'b1;
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .flush    (redirect_valid),
        .din_instr(imem_rsp_data),
        .din_pc   (pc),
        .ready    (id_ready),
        .valid    (id_valid),
        .instr    (id_instr),
        .pc       (id_pc),
        .count    (fetch_count)
    );
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a latency-programmable imem model.
module tb_if_stage;
    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_op;
    logic        fetch_misaligned;
    logic [31:0] fetch_count;

    int pass_n = 0;
    int total_n = 0;

    int          lat = 1;
    int          acc_n = 0;
    int          seen_n = 0;
    logic [31:0] acc_q[$];
    logic [31:0] paddr;
    bit          pend = 0;
    int          cnt = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [6:0]  op;
    } vec_t;
    vec_t tbl[10];

    if_stage dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_op           (id_op),
        .fetch_misaligned(fetch_misaligned),
        .fetch_count     (fetch_count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h0050_0093 + (a << 7);
    endfunction

    always @(posedge clk) begin
        if (!rst && imem_req_valid && imem_req_ready) begin
            paddr = imem_addr;
            acc_q.push_back(imem_addr);
            acc_n++;
        end
    end

    always @(negedge clk) begin
        imem_rsp_valid = 0;
        if (rst) begin
            pend = 0;
            seen_n = acc_n;
        end else begin
            if (acc_n != seen_n) begin
                seen_n = acc_n;
                pend = 1;
                cnt = lat;
            end
            if (pend) begin
                if (cnt <= 1) begin
                    imem_rsp_valid = 1;
                    imem_rsp_data = word(paddr);
                    pend = 0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wait_valid(input string tag);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (id_valid) begin ok = 1; break; end
        end
        if (!ok) begin
            total_n++;
            $display("FAIL %s: id_valid timeout", tag);
        end
    endtask

    task automatic wait_rsp(input string tag);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (imem_rsp_valid) begin ok = 1; break; end
        end
        if (!ok) begin
            total_n++;
            $display("FAIL %s: imem_rsp_valid timeout", tag);
        end
    endtask

    task automatic wait_acc(input string tag);
        int n0 = acc_n;
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (acc_n > n0) begin ok = 1; break; end
        end
        if (!ok) begin
            total_n++;
            $display("FAIL %s: request timeout", tag);
        end
    endtask

    task automatic do_reset(input logic rdy);
        rst = 1;
        redirect_valid = 0;
        redirect_pc = 0;
        id_ready = rdy;
        repeat (2) @(negedge clk);
        #1 rst = 0;
        check("req_low_after_release", {31'd0, imem_req_valid}, 32'd0);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        redirect_valid = 1;
        redirect_pc = tgt;
        @(negedge clk); #1;
        redirect_valid = 0;
    endtask

    function automatic logic [31:0] qat(input int idx);
        if (idx < acc_q.size()) return acc_q[idx];
        return 32'hDEAD_BEEF;
    endfunction

    initial begin
        int qb;
        int a0;
        logic [31:0] hold_pc;
        logic [31:0] hold_instr;

        tbl[0] = '{32'h00, 32'h0050_0093, 7'h13};
        tbl[1] = '{32'h04, 32'h0050_0293, 7'h13};
        tbl[2] = '{32'h08, 32'h0050_0493, 7'h13};
        tbl[3] = '{32'h0C, 32'h0050_0693, 7'h13};
        tbl[4] = '{32'h10, 32'h0050_0893, 7'h13};
        tbl[5] = '{32'h14, 32'h0050_0A93, 7'h13};
        tbl[6] = '{32'h18, 32'h0050_0C93, 7'h13};
        tbl[7] = '{32'h1C, 32'h0050_0E93, 7'h13};
        tbl[8] = '{32'h20, 32'h0050_1093, 7'h13};
        tbl[9] = '{32'h24, 32'h0050_1293, 7'h13};

        rst = 1;
        imem_req_ready = 1;
        imem_rsp_data = 0;
        redirect_valid = 0;
        redirect_pc = 0;
        id_ready = 1;
        #2;
        check("rst_id_instr", id_instr, 32'h0000_0013);
        check("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_misaligned", {31'd0, fetch_misaligned}, 32'd0);
        check("rst_op", {25'd0, id_op}, 32'h13);

        // Sequential stream with 1-cycle memory.
        lat = 1;
        do_reset(1);
        qb = acc_q.size();
        for (int i = 0; i < 10; i++) begin
            wait_valid($sformatf("t1_%0d", i));
            check($sformatf("t1_pc_%0d", i), id_pc, tbl[i].pc);
            check($sformatf("t1_instr_%0d", i), id_instr, tbl[i].instr);
            check($sformatf("t1_op_%0d", i), {25'd0, id_op}, {25'd0, tbl[i].op});
            check($sformatf("t1_addr_%0d", i), qat(qb + i), tbl[i].pc);
        end
        @(negedge clk); #1;
        check("t1_count", fetch_count, 32'd10);

        // Back-pressure holds the output and blocks new requests.
        do_reset(0);
        wait_valid("t2");
        check("t2_instr", id_instr, 32'h0050_0093);
        a0 = acc_n;
        hold_pc = id_pc;
        hold_instr = id_instr;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("t2_hold_valid", {31'd0, id_valid}, 32'd1);
            check("t2_hold_instr", id_instr, hold_instr);
            check("t2_hold_pc", id_pc, hold_pc);
            check("t2_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        check("t2_acc_during_hold", acc_n, a0);
        id_ready = 1;
        #1;
        check("t2_req_on_ready", {31'd0, imem_req_valid}, 32'd1);
        check("t2_req_addr", imem_addr, 32'h4);
        @(negedge clk); #1;
        check("t2_one_req", acc_n, a0 + 1);
        check("t2_count", fetch_count, 32'd1);
        check("t2_drained", {31'd0, id_valid}, 32'd0);

        // Redirect in WAIT with a slow response: DROP then refetch.
        lat = 3;
        do_reset(1);
        wait_acc("t3_acc");
        qb = acc_q.size();
        redirect(32'h100);
        check("t3_drop_noreq", {31'd0, imem_req_valid}, 32'd0);
        check("t3_drop_valid", {31'd0, id_valid}, 32'd0);
        @(negedge clk); #1;
        check("t3_late_rsp", {31'd0, imem_rsp_valid}, 32'd1);
        check("t3_still_noreq", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk); #1;
        check("t3_discarded", {31'd0, id_valid}, 32'd0);
        check("t3_next_addr", imem_addr, 32'h100);
        wait_valid("t3");
        check("t3_pc", id_pc, 32'h100);
        check("t3_instr", id_instr, 32'h0050_8093);
        check("t3_first_acc", qat(qb), 32'h100);

        // Redirect coincident with the response.
        lat = 2;
        do_reset(1);
        wait_rsp("t4_rsp");
        qb = acc_q.size();
        redirect(32'h200);
        check("t4_discarded", {31'd0, id_valid}, 32'd0);
        check("t4_nop", id_instr, 32'h0000_0013);
        wait_valid("t4");
        check("t4_pc", id_pc, 32'h200);
        check("t4_instr", id_instr, 32'h0051_0093);
        check("t4_first_acc", qat(qb), 32'h200);

        // Misaligned target is aligned and flagged stickily.
        lat = 1;
        check("t5_mis_before", {31'd0, fetch_misaligned}, 32'd0);
        wait_rsp("t5_rsp");
        redirect(32'h102);
        check("t5_mis_set", {31'd0, fetch_misaligned}, 32'd1);
        check("t5_addr", imem_addr, 32'h100);
        wait_valid("t5a");
        check("t5_pc", id_pc, 32'h100);
        @(negedge clk); #1;
        redirect(32'h40);
        wait_valid("t5b");
        check("t5_pc40", id_pc, 32'h40);
        check("t5_mis_sticky", {31'd0, fetch_misaligned}, 32'd1);

        // Asynchronous reset in the middle of WAIT.
        lat = 4;
        wait_acc("t6_acc");
        rst = 1;
        #1;
        check("t6_instr", id_instr, 32'h0000_0013);
        check("t6_valid", {31'd0, id_valid}, 32'd0);
        check("t6_req", {31'd0, imem_req_valid}, 32'd0);
        check("t6_addr", imem_addr, 32'd0);
        check("t6_pc", id_pc, 32'd0);
        check("t6_count", fetch_count, 32'd0);
        check("t6_mis", {31'd0, fetch_misaligned}, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 0;
        check("t6_req_release", {31'd0, imem_req_valid}, 32'd0);
        qb = acc_q.size();
        wait_valid("t6");
        check("t6_first_acc", qat(qb), 32'd0);
        check("t6_first_pc", id_pc, 32'd0);
        check("t6_first_instr", id_instr, 32'h0050_0093);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
